// File: rtl/demux_deser_1to32_pkg.sv
// -----------------------------------------------------------------------------
// demux_deser_1to32_pkg
//   Shared definitions for the 1-to-32 serial-to-parallel demultiplexer:
//   word/select widths, the two-state FSM encoding and helpers that give the
//   first and last bit positions for either bit order.
// -----------------------------------------------------------------------------
package demux_deser_1to32_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

  // COLLECT gathers bits, FULL presents a complete word to the consumer.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // Position written by the first bit of a word.
  function automatic sel_t start_sel(input bit lsb_first);
    return lsb_first ? sel_t'(0) : sel_t'(WORD_W - 1);
  endfunction

  // Position written by the last bit of a word.
  function automatic sel_t final_sel(input bit lsb_first);
    return lsb_first ? sel_t'(WORD_W - 1) : sel_t'(0);
  endfunction

endpackage : demux_deser_1to32_pkg

// File: rtl/demux_deser_1to32_dec5to32.sv
// -----------------------------------------------------------------------------
// dec5to32
//   One-hot 5-to-32 decoder with enable. Drives the per-bit write enables of
//   the deserializer word register.
//
//   Ports
//     sel_i  [4:0]   bit position to enable
//     en_i           qualifies the decode; all outputs low when 0
//     dec_o  [31:0]  one-hot (or all-zero) write enables
//
//   GATE_DLY is the gate propagation delay used by gate-level simulation
//   netlists of this cell; the RTL view is zero-delay and only range-checks it.
// -----------------------------------------------------------------------------
module dec5to32
  import demux_deser_1to32_pkg::*;
#(
  parameter int GATE_DLY = 0
) (
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              en_i,
  output logic [WORD_W-1:0] dec_o
);

  if (GATE_DLY < 0) begin : g_bad_gate_dly
    $error("dec5to32: GATE_DLY must be non-negative");
  end

  // NOTE: combinational blocks assign every output a default first and use
  // blocking assignments, so no path leaves a value held and no latch is inferred.
  always_comb begin
    dec_o        = '0;
    dec_o[sel_i] = en_i;
  end

endmodule : dec5to32

// File: rtl/demux_deser_1to32.sv
// -----------------------------------------------------------------------------
// demux_deser_1to32
//   Serial-to-parallel demultiplexer: accepts one bit per bit transfer
//   (InValid & InReady) and writes it into Out[Select]. After 32 bits the word
//   is presented with OutValid until the consumer takes it (OutValid &
//   OutReady); only then does collection of the next word start.
//
//   Parameters
//     LSB_FIRST  1: first bit lands in Out[0], Select counts 0..31
//                0: first bit lands in Out[31], Select counts 31..0
//     GATE_DLY   gate delay (ps) for gate-level views; forwarded to dec5to32
//
//   Ports
//     Clk        rising-edge clock
//     Resetn     synchronous active-low reset
//     In         serial data bit
//     InValid    In carries a bit this cycle
//     InReady    block accepts a bit this cycle (state COLLECT)
//     Clear      abort the partial word, restart at the start position
//     Out[31:0]  assembled word (unwritten bits read 0 while collecting)
//     OutValid   Out holds a complete word (state FULL)
//     OutReady   consumer takes Out this cycle
//     Select[4:0] position the next accepted bit is written to
// -----------------------------------------------------------------------------
module demux_deser_1to32
  import demux_deser_1to32_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int GATE_DLY  = 50
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              In,
  input  logic              InValid,
  output logic              InReady,
  input  logic              Clear,
  output logic [WORD_W-1:0] Out,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [SEL_W-1:0]  Select
);

  localparam sel_t SelStart = start_sel(LSB_FIRST);
  localparam sel_t SelFinal = final_sel(LSB_FIRST);

  state_e state_q, state_d;
  sel_t   sel_q, sel_d;
  word_t  out_q, out_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  logic   bit_xfer;
  logic   word_xfer;
  word_t  wr_en;

  // Ready/valid are registered copies of the state, so the handshakes can be
  // formed directly from them without decoding state_q.
  assign bit_xfer  = InValid  & in_ready_q;
  assign word_xfer = OutReady & out_valid_q;

  // Only the addressed bit is enabled, and only on an actual bit transfer.
  dec5to32 #(
    .GATE_DLY (GATE_DLY)
  ) u_dec (
    .sel_i (sel_q),
    .en_i  (bit_xfer),
    .dec_o (wr_en)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (Clear) begin
      // Clear outranks any transfer happening on the same edge.
      state_d     = COLLECT;
      sel_d       = SelStart;
      out_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (bit_xfer) begin
            out_d = (out_q & ~wr_en) | (wr_en & {WORD_W{In}});
            if (sel_q == SelFinal) begin
              state_d     = FULL;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end else if (LSB_FIRST) begin
              sel_d = sel_q + 1'b1;
            end else begin
              sel_d = sel_q - 1'b1;
            end
          end
        end
        FULL: begin
          // Taking the word starts a fresh, all-zero word; there is no
          // same-cycle bypass, so the next bit is accepted one cycle later.
          if (word_xfer) begin
            state_d     = COLLECT;
            sel_d       = SelStart;
            out_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = COLLECT;
          sel_d       = SelStart;
          out_d       = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: Resetn is sampled only at the clock edge (synchronous reset); state
  // registers use non-blocking assignments so all of them update together.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q     <= COLLECT;
      sel_q       <= SelStart;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign Out      = out_q;
  assign Select   = sel_q;

endmodule : demux_deser_1to32

// File: tb/tb_demux_deser_1to32.sv
// -----------------------------------------------------------------------------
// tb_demux_deser_1to32
//   Drives an LSB-first and an MSB-first instance with the same serial stream
//   and compares both against a word-level reference model: a bit counter, a
//   full flag and two words filled by index (n and 31-n).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_deser_1to32;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic        In;
  logic        InValid;
  logic        Clear;
  logic        OutReady;

  logic        in_ready_l, out_valid_l;
  logic [31:0] out_l;
  logic [4:0]  sel_l;
  logic        in_ready_m, out_valid_m;
  logic [31:0] out_m;
  logic [4:0]  sel_m;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_full;
  int          m_n;
  logic [31:0] m_lsb;
  logic [31:0] m_msb;
  bit          m_acc;

  // Back-to-back bookkeeping
  int          ov_cnt;
  int          ir_low_cnt;
  logic [31:0] seen[$];

  always #5 Clk = ~Clk;

  demux_deser_1to32 #(.LSB_FIRST(1'b1), .GATE_DLY(0)) dut_lsb (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .In       (In),
    .InValid  (InValid),
    .InReady  (in_ready_l),
    .Clear    (Clear),
    .Out      (out_l),
    .OutValid (out_valid_l),
    .OutReady (OutReady),
    .Select   (sel_l)
  );

  demux_deser_1to32 #(.LSB_FIRST(1'b0), .GATE_DLY(0)) dut_msb (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .In       (In),
    .InValid  (InValid),
    .InReady  (in_ready_m),
    .Clear    (Clear),
    .Out      (out_m),
    .OutValid (out_valid_m),
    .OutReady (OutReady),
    .Select   (sel_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_full = 1'b0;
    m_n    = 0;
    m_lsb  = '0;
    m_msb  = '0;
  endtask

  task automatic model_edge(input logic b, input logic vld, input logic clr,
                            input logic ordy, input logic rstn);
    m_acc = 1'b0;
    if (!rstn || clr) begin
      model_clear();
    end else if (m_full) begin
      if (ordy) model_clear();
    end else if (vld) begin
      m_acc          = 1'b1;
      m_lsb[m_n]     = b;
      m_msb[31 - m_n] = b;
      m_n++;
      if (m_n == 32) m_full = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("in_ready_lsb",  {31'b0, in_ready_l},  {31'b0, ~m_full});
    chk("in_ready_msb",  {31'b0, in_ready_m},  {31'b0, ~m_full});
    chk("out_valid_lsb", {31'b0, out_valid_l}, {31'b0, m_full});
    chk("out_valid_msb", {31'b0, out_valid_m}, {31'b0, m_full});
    chk("out_lsb", out_l, m_lsb);
    chk("out_msb", out_m, m_msb);
    if (!m_full) begin
      chk("select_lsb", {27'b0, sel_l}, 32'(m_n));
      chk("select_msb", {27'b0, sel_m}, 32'(31 - m_n));
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, sample at +1.
  task automatic step(input logic b, input logic vld, input logic clr,
                      input logic ordy, input logic rstn);
    In       = b;
    InValid  = vld;
    Clear    = clr;
    OutReady = ordy;
    Resetn   = rstn;
    @(posedge Clk);
    model_edge(b, vld, clr, ordy, rstn);
    #1;
    check_all();
    if (out_valid_l) begin
      ov_cnt++;
      seen.push_back(out_l);
    end
    if (!in_ready_l) ir_low_cnt++;
  endtask

  // Feed one word serially (bit 0 of 'word' first). vmode 0: InValid held
  // high; vmode 1: InValid alternates 0,1,0,1... Ends when 32 bits are taken.
  task automatic send_word(input logic [31:0] word, input int vmode, input logic ordy);
    int idx = 0;
    for (int cyc = 0; cyc < 200 && idx < 32; cyc++) begin
      logic vld;
      vld = (vmode == 0) ? 1'b1 : logic'(cyc % 2 == 1);
      step(word[idx], vld, 1'b0, ordy, 1'b1);
      if (m_acc) idx++;
    end
    chk("send_word_budget", 32'(idx), 32'd32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    In = 1'b0; InValid = 1'b0; Clear = 1'b0; OutReady = 1'b0; Resetn = 1'b0;
    model_clear();
    m_acc = 1'b0;
    ov_cnt = 0;
    ir_low_cnt = 0;

    // Reset state
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_out", out_l, 32'h0);
    chk("reset_sel_msb", {27'b0, sel_m}, 32'd31);

    // Continuous word, no consumer: both bit orders, then 10 stable cycles
    send_word(32'hA5A5_0F0F, 0, 1'b0);
    chk("word_a5_lsb", out_l, 32'hA5A5_0F0F);
    chk("word_a5_msb", out_m, 32'hF0F0_A5A5);
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("word_a5_hold", out_l, 32'hA5A5_0F0F);

    // Word transfer back to collecting
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("after_take_ready", {31'b0, in_ready_l}, 32'd1);

    // InValid alternating: word completes after 64 cycles
    send_word(32'h1234_5678, 1, 1'b0);
    chk("toggle_word", out_l, 32'h1234_5678);

    // Reset while FULL beats a simultaneous Clear and word transfer
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_full_valid", {31'b0, out_valid_l}, 32'd0);
    chk("rst_full_sel", {27'b0, sel_l}, 32'd0);

    // Clear after 17 bits, with a bit offered on the Clear edge
    for (int i = 0; i < 17; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clear_sel", {27'b0, sel_l}, 32'd0);
    chk("clear_out", out_l, 32'h0);
    send_word(32'hFFFF_FFFF, 0, 1'b0);
    chk("ones_word", out_l, 32'hFFFF_FFFF);
    // Clear in FULL wins over a word transfer
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // OutReady idle while collecting has no effect
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Back-to-back words with OutReady held high
    ov_cnt = 0;
    ir_low_cnt = 0;
    seen.delete();
    send_word(32'h0000_0001, 0, 1'b1);
    send_word(32'h8000_0000, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("b2b_presented", 32'(ov_cnt), 32'd2);
    chk("b2b_gap", 32'(ir_low_cnt), 32'd2);
    chk("b2b_seen_n", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      chk("b2b_word0", seen[0], 32'h0000_0001);
      chk("b2b_word1", seen[1], 32'h8000_0000);
    end

    // Random traffic with occasional Clear and reset
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 63) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 199) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_deser_1to32
